// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS control unit (Moore FSM over IF/ID/EX/MEM/WB)
module multicycle_ctrl #(
    parameter bit JAL_EN = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] OP,
    input  logic [5:0] func,
    input  logic       Zero,
    output logic       PC_Write,
    output logic       IR_Write,
    output logic       Write_Reg,
    output logic       Mem_Write,
    output logic [1:0] PC_s,
    output logic [1:0] w_r_s,
    output logic [1:0] wr_data_s,
    output logic       rt_imm_s,
    output logic       imm_s,
    output logic [2:0] ALU_OP,
    output logic [2:0] State
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5
    } state_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_NOR = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_SLL = 3'b111;

    state_t     state_q, state_d;
    logic       r_func_ok;
    logic [2:0] r_alu;
    logic       is_r, is_jr, is_j, is_jal, is_beq, is_bne;
    logic       is_addi, is_andi, is_ori, is_xori, is_lw, is_sw;
    logic       is_ialu, is_legal;
    logic [2:0] ex_alu;
    logic       ex_rt_imm, ex_imm_s;

    always_comb begin
        r_func_ok = 1'b1;
        r_alu     = ALU_AND;
        case (func)
            6'b100000: r_alu = ALU_ADD;
            6'b100010: r_alu = ALU_SUB;
            6'b100100: r_alu = ALU_AND;
            6'b100101: r_alu = ALU_OR;
            6'b100110: r_alu = ALU_XOR;
            6'b100111: r_alu = ALU_NOR;
            6'b101010: r_alu = ALU_SLT;
            6'b000100: r_alu = ALU_SLL;
            default:   r_func_ok = 1'b0;
        endcase
    end

    assign is_r     = (OP == 6'b000000) && r_func_ok;
    assign is_jr    = (OP == 6'b000000) && (func == 6'b001000);
    assign is_j     = (OP == 6'b000010);
    assign is_jal   = JAL_EN && (OP == 6'b000011);
    assign is_beq   = (OP == 6'b000100);
    assign is_bne   = (OP == 6'b000101);
    assign is_addi  = (OP == 6'b001000);
    assign is_andi  = (OP == 6'b001100);
    assign is_ori   = (OP == 6'b001101);
    assign is_xori  = (OP == 6'b001110);
    assign is_lw    = (OP == 6'b100011);
    assign is_sw    = (OP == 6'b101011);
    assign is_ialu  = is_addi | is_andi | is_ori | is_xori;
    assign is_legal = is_r | is_jr | is_j | is_jal | is_beq | is_bne | is_ialu | is_lw | is_sw;

    // ALU controls chosen in EX; held unchanged through MEM and WB of the same instruction
    always_comb begin
        ex_alu    = ALU_AND;
        ex_rt_imm = 1'b0;
        ex_imm_s  = 1'b0;
        if (is_r) begin
            ex_alu = r_alu;
        end else if (is_addi || is_lw || is_sw) begin
            ex_alu    = ALU_ADD;
            ex_rt_imm = 1'b1;
            ex_imm_s  = 1'b1;
        end else if (is_andi) begin
            ex_alu    = ALU_AND;
            ex_rt_imm = 1'b1;
        end else if (is_ori) begin
            ex_alu    = ALU_OR;
            ex_rt_imm = 1'b1;
        end else if (is_xori) begin
            ex_alu    = ALU_XOR;
            ex_rt_imm = 1'b1;
        end else if (is_beq || is_bne) begin
            ex_alu   = ALU_SUB;
            ex_imm_s = 1'b1;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE: state_d = S_IF;
            S_IF:   state_d = S_ID;
            S_ID:   state_d = (is_j || is_jal || !is_legal) ? S_IF : S_EX;
            S_EX: begin
                if (is_lw || is_sw)     state_d = S_MEM;
                else if (is_r || is_ialu) state_d = S_WB;
                else                    state_d = S_IF;
            end
            S_MEM:  state_d = is_lw ? S_WB : S_IF;
            S_WB:   state_d = S_IF;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Outputs follow the current state and latched IR; Zero only matters for branches in EX
    always_comb begin
        PC_Write  = 1'b0;
        IR_Write  = 1'b0;
        Write_Reg = 1'b0;
        Mem_Write = 1'b0;
        PC_s      = 2'b00;
        w_r_s     = 2'b00;
        wr_data_s = 2'b00;
        rt_imm_s  = 1'b0;
        imm_s     = 1'b0;
        ALU_OP    = ALU_AND;
        State     = state_q;
        case (state_q)
            S_IF: begin
                PC_Write = 1'b1;
                IR_Write = 1'b1;
            end
            S_ID: begin
                if (is_j || is_jal) begin
                    PC_Write = 1'b1;
                    PC_s     = 2'b10;
                end
                if (is_jal) begin
                    Write_Reg = 1'b1;
                    w_r_s     = 2'b10;
                    wr_data_s = 2'b10;
                end
            end
            S_EX: begin
                ALU_OP   = ex_alu;
                rt_imm_s = ex_rt_imm;
                imm_s    = ex_imm_s;
                if (is_jr) begin
                    PC_Write = 1'b1;
                    PC_s     = 2'b11;
                end else if (is_beq) begin
                    PC_Write = Zero;
                    PC_s     = 2'b01;
                end else if (is_bne) begin
                    PC_Write = !Zero;
                    PC_s     = 2'b01;
                end
            end
            S_MEM: begin
                ALU_OP    = ex_alu;
                rt_imm_s  = ex_rt_imm;
                imm_s     = ex_imm_s;
                Mem_Write = is_sw;
            end
            S_WB: begin
                ALU_OP    = ex_alu;
                rt_imm_s  = ex_rt_imm;
                imm_s     = ex_imm_s;
                Write_Reg = 1'b1;
                w_r_s     = is_r ? 2'b00 : 2'b01;
                wr_data_s = is_lw ? 2'b01 : 2'b00;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized instruction-level check of multicycle_ctrl (JAL_EN=1 and 0)
module tb_multicycle_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [5:0] OP = 6'd0;
    logic [5:0] func = 6'd0;
    logic       Zero = 1'b0;

    logic       pcw_a, irw_a, wr_a, mw_a, rti_a, imm_a;
    logic [1:0] pcs_a, wrs_a, wds_a;
    logic [2:0] alu_a, st_a;
    logic       pcw_b, irw_b, wr_b, mw_b, rti_b, imm_b;
    logic [1:0] pcs_b, wrs_b, wds_b;
    logic [2:0] alu_b, st_b;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    multicycle_ctrl #(.JAL_EN(1'b1)) dut_a (
        .Clk(Clk), .Reset(Reset), .OP(OP), .func(func), .Zero(Zero),
        .PC_Write(pcw_a), .IR_Write(irw_a), .Write_Reg(wr_a), .Mem_Write(mw_a),
        .PC_s(pcs_a), .w_r_s(wrs_a), .wr_data_s(wds_a), .rt_imm_s(rti_a),
        .imm_s(imm_a), .ALU_OP(alu_a), .State(st_a)
    );

    multicycle_ctrl #(.JAL_EN(1'b0)) dut_b (
        .Clk(Clk), .Reset(Reset), .OP(OP), .func(func), .Zero(Zero),
        .PC_Write(pcw_b), .IR_Write(irw_b), .Write_Reg(wr_b), .Mem_Write(mw_b),
        .PC_s(pcs_b), .w_r_s(wrs_b), .wr_data_s(wds_b), .rt_imm_s(rti_b),
        .imm_s(imm_b), .ALU_OP(alu_b), .State(st_b)
    );

    typedef enum {K_NOP, K_R, K_JR, K_IALU, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL} kind_t;

    // Packed view: {PC_Write, IR_Write, Write_Reg, Mem_Write, PC_s, w_r_s, wr_data_s, rt_imm_s, imm_s, ALU_OP, State}
    function automatic logic [17:0] pack(input logic pcw, irw, wr, mw, input logic [1:0] pcs, wrs, wds,
                                         input logic rti, imm, input logic [2:0] alu, st);
        return {pcw, irw, wr, mw, pcs, wrs, wds, rti, imm, alu, st};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int r_alu_code(input logic [5:0] fn);
        case (fn)
            6'h20: return 2;  6'h22: return 3;  6'h24: return 0;  6'h25: return 1;
            6'h26: return 4;  6'h27: return 5;  6'h2A: return 6;  6'h04: return 7;
            default: return -1;
        endcase
    endfunction

    function automatic kind_t classify(input logic [5:0] op, fn, input bit jal_en);
        case (op)
            6'd0:  return (fn == 6'h08) ? K_JR : (r_alu_code(fn) >= 0 ? K_R : K_NOP);
            6'd2:  return K_J;
            6'd3:  return jal_en ? K_JAL : K_NOP;
            6'd4:  return K_BEQ;
            6'd5:  return K_BNE;
            6'd8, 6'd12, 6'd13, 6'd14: return K_IALU;
            6'd35: return K_LW;
            6'd43: return K_SW;
            default: return K_NOP;
        endcase
    endfunction

    // State walk of one instruction, IF first
    function automatic int n_cycles(input kind_t k);
        case (k)
            K_R, K_IALU, K_SW: return 4;
            K_LW:              return 5;
            K_BEQ, K_BNE, K_JR: return 3;
            default:           return 2;
        endcase
    endfunction

    function automatic int state_at(input kind_t k, input int i);
        if (i < 3) return i + 1;
        if (k == K_LW) return (i == 3) ? 4 : 5;
        if (k == K_SW) return 4;
        return 5;
    endfunction

    // Expected {alu, rt_imm, imm_s} the instruction uses from EX onward
    function automatic logic [4:0] alu_fields(input kind_t k, input logic [5:0] op, fn);
        int c;
        case (k)
            K_R:          begin c = r_alu_code(fn); return {c[2:0], 2'b00}; end
            K_LW, K_SW:   return {3'd2, 2'b11};
            K_BEQ, K_BNE: return {3'd3, 2'b01};
            K_IALU: begin
                if (op == 6'd8)  return {3'd2, 2'b11};
                if (op == 6'd12) return {3'd0, 2'b10};
                if (op == 6'd13) return {3'd1, 2'b10};
                return {3'd4, 2'b10};
            end
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [17:0] expect_out(input kind_t k, input logic [5:0] op, fn,
                                               input int st, input logic z);
        logic pcw = 0, irw = 0, wr = 0, mw = 0, rti = 0, imm = 0;
        logic [1:0] pcs = 0, wrs = 0, wds = 0;
        logic [2:0] alu = 0;
        logic [4:0] af = alu_fields(k, op, fn);
        if (st >= 3) begin
            alu = af[4:2]; rti = af[1]; imm = af[0];
        end
        case (st)
            1: begin pcw = 1; irw = 1; end
            2: if (k == K_J || k == K_JAL) begin
                pcw = 1; pcs = 2'b10;
                if (k == K_JAL) begin wr = 1; wrs = 2'b10; wds = 2'b10; end
            end
            3: begin
                if (k == K_JR)  begin pcw = 1;  pcs = 2'b11; end
                if (k == K_BEQ) begin pcw = z;  pcs = 2'b01; end
                if (k == K_BNE) begin pcw = !z; pcs = 2'b01; end
            end
            4: mw = (k == K_SW);
            5: begin
                wr = 1;
                wrs = (k == K_R) ? 2'b00 : 2'b01;
                wds = (k == K_LW) ? 2'b01 : 2'b00;
            end
            default: ;
        endcase
        return pack(pcw, irw, wr, mw, pcs, wrs, wds, rti, imm, alu, st[2:0]);
    endfunction

    function automatic logic [17:0] obs_a();
        return pack(pcw_a, irw_a, wr_a, mw_a, pcs_a, wrs_a, wds_a, rti_a, imm_a, alu_a, st_a);
    endfunction

    function automatic logic [17:0] obs_b();
        return pack(pcw_b, irw_b, wr_b, mw_b, pcs_b, wrs_b, wds_b, rti_b, imm_b, alu_b, st_b);
    endfunction

    // Runs one instruction cycle by cycle; reset_at >= 0 aborts with a reset during that cycle
    task automatic run_instr(input logic [5:0] op, fn, input int zmode, input int reset_at);
        kind_t ka = classify(op, fn, 1'b1);
        kind_t kb = classify(op, fn, 1'b0);
        for (int i = 0; i < n_cycles(ka); i++) begin
            @(negedge Clk);
            if (i == 0) begin OP = op; func = fn; end
            Zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            #1;
            check($sformatf("a op=%0h fn=%0h cyc=%0d", op, fn, i), 32'(obs_a()),
                  32'(expect_out(ka, op, fn, state_at(ka, i), Zero)));
            check($sformatf("b op=%0h fn=%0h cyc=%0d", op, fn, i), 32'(obs_b()),
                  32'(expect_out(kb, op, fn, state_at(kb, i), Zero)));
            if (i == reset_at) begin
                #2 Reset = 1'b1;
                #1;
                check("async_reset_a", 32'(obs_a()), 32'd0);
                check("async_reset_b", 32'(obs_b()), 32'd0);
                @(negedge Clk);
                Reset = 1'b0;
                #1;
                check("idle_after_reset_a", 32'(obs_a()), 32'd0);
                check("idle_after_reset_b", 32'(obs_b()), 32'd0);
                return;
            end
        end
    endtask

    logic [5:0] op_pool [16] = '{6'd0, 6'd0, 6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8,
                                 6'd12, 6'd13, 6'd14, 6'd35, 6'd43, 6'd63, 6'd9, 6'd0};
    logic [5:0] fn_pool [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h2A, 6'h04, 6'h08, 6'h00, 6'h21, 6'h3F};

    initial begin
        #1;
        check("reset_hold_a", 32'(obs_a()), 32'd0);
        check("reset_hold_b", 32'(obs_b()), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        check("idle_a", 32'(obs_a()), 32'd0);
        check("idle_b", 32'(obs_b()), 32'd0);

        run_instr(6'd0, 6'h20, -1, 2);
        run_instr(6'd0, 6'h20, -1, -1);
        run_instr(6'd35, 6'h00, -1, -1);
        run_instr(6'd43, 6'h00, -1, -1);
        run_instr(6'd4, 6'h00, 1, -1);
        run_instr(6'd5, 6'h00, 1, -1);
        run_instr(6'd4, 6'h00, 0, -1);
        run_instr(6'd5, 6'h00, 0, -1);
        run_instr(6'd3, 6'h00, -1, -1);
        run_instr(6'd2, 6'h00, -1, -1);
        run_instr(6'd0, 6'h08, -1, -1);
        run_instr(6'd63, 6'h00, -1, -1);
        run_instr(6'd0, 6'h00, -1, -1);
        run_instr(6'd13, 6'h00, -1, -1);

        for (int n = 0; n < 400; n++) begin
            logic [5:0] op = op_pool[$urandom_range(0, 15)];
            logic [5:0] fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 11)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            run_instr(op, fn, -1, ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 3)) : -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle MIPS control unit: sequences the 32x32 register file, ALU, data memory and PC/IR registers of the R/I/J datapath.
- Moore FSM; outputs decode from current state plus the latched IR fields OP and func.
- Supports R-type (add, sub, and, or, xor, nor, slt, sllv, jr), I-type (addi, andi, ori, xori, lw, sw, beq, bne) and J-type (j, jal).

Parameters:
JAL_EN  1  1 = jal supported; 0 = jal opcode treated as illegal

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous active-high reset
OP  in  6  IR[31:26]
func  in  6  IR[5:0]
Zero  in  1  ALU zero flag, valid in EX
PC_Write  out  1  PC load enable
IR_Write  out  1  IR load enable
Write_Reg  out  1  register file write enable
Mem_Write  out  1  data memory write enable
PC_s  out  2  PC source: 00 PC+4, 01 branch target, 10 jump target, 11 register A
w_r_s  out  2  write address select: 00 rd, 01 rt, 10 $31
wr_data_s  out  2  write data select: 00 ALU F reg, 01 memory data reg, 10 PC (already PC+4)
rt_imm_s  out  1  ALU B operand: 0 register B, 1 extended immediate
imm_s  out  1  immediate extension: 0 zero-extend, 1 sign-extend
ALU_OP  out  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 NOR, 110 SLT, 111 SLL
State  out  3  current state, for debug

Behaviour:
- States: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5. Codes 6 and 7 go to IDLE on the next clock, with all outputs 0.
- Reset (async, any cycle, including mid-instruction): State=IDLE and every output 0 immediately. IDLE always goes to IF on the next clock.
- IF: PC_Write=1, IR_Write=1, PC_s=00. Always goes to ID.
- ID: operands latch in the datapath.
  - j: PC_Write=1, PC_s=10, then IF.
  - jal: same as j, plus Write_Reg=1, w_r_s=10, wr_data_s=10; then IF.
  - Illegal OP, or OP=0 with an unlisted func: no enables asserted, then IF (treated as a NOP).
  - All others: go to EX.
- EX:
  - R-type: ALU_OP from func: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 000100 SLL; rt_imm_s=0; then WB.
  - jr (OP=0, func=001000): PC_Write=1, PC_s=11, then IF.
  - addi: ADD, rt_imm_s=1, imm_s=1; then WB.
  - andi / ori / xori: AND / OR / XOR, rt_imm_s=1, imm_s=0; then WB.
  - lw / sw: ADD, rt_imm_s=1, imm_s=1; then MEM.
  - beq / bne: SUB, rt_imm_s=0, imm_s=1, PC_s=01. PC_Write = Zero for beq, !Zero for bne. Then IF.
- MEM:
  - sw: Mem_Write=1, then IF.
  - lw: read cycle, no enables asserted, then WB.
- WB: Write_Reg=1.
  - R-type: w_r_s=00, wr_data_s=00.
  - I-type ALU: w_r_s=01, wr_data_s=00.
  - lw: w_r_s=01, wr_data_s=01.
  - Then IF.
- ALU_OP, rt_imm_s and imm_s hold their EX values through MEM and WB of the same instruction. In all other states they are 0.
- Any enable not listed for a state is 0. PC_Write is never asserted in MEM or WB.
- Write to $0 is blocked by the register file itself; the controller still asserts Write_Reg for rd=0.
- Cycles per instruction (IF to next IF): R/I-ALU 4, lw 5, sw 4, beq/bne 3, jr 3, j/jal 2.

Test Plan:
- Reset: assert Reset mid-EX of an add -> State=0 and all outputs 0 in the same cycle. Release -> IDLE, then IF with PC_Write=IR_Write=1.
- add (OP=000000, func=100000): states IF,ID,EX,WB. EX shows ALU_OP=010, rt_imm_s=0. WB shows Write_Reg=1, w_r_s=00, wr_data_s=00. Next state IF.
- lw (100011) then sw (101011):
  - lw runs 5 cycles; MEM has no enables; WB has w_r_s=01, wr_data_s=01, imm_s=1.
  - sw runs 4 cycles with Mem_Write=1 only in MEM and Write_Reg never asserted.
- beq (000100) with Zero=1 -> EX shows PC_Write=1, PC_s=01. bne (000101) with Zero=1 -> PC_Write=0. Both return to IF after 3 cycles.
- jal (000011) -> ID shows PC_Write=1, PC_s=10, Write_Reg=1, w_r_s=10, wr_data_s=10, then IF. With JAL_EN=0 -> no enables asserted in ID.
- Illegal OP 111111 and R-type func 000000 -> IF, ID, IF with no Write_Reg, Mem_Write or PC_Write outside IF. ori (001101) -> imm_s=0, ALU_OP=001.
